// File: rtl/gearbox_rx_flex.sv
// ============================================================================
// gearbox_rx_flex : PMA_W -> 66b RX gearbox with one-bit slip, LSB-first
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gearbox_rx_flex #(
  parameter int PMA_W  = 64,
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DATA_W + HEAD_W + PMA_W)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              lock_v_i,
  input  logic [PMA_W-1:0]  data_i,
  input  logic              slip_v_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int BLOCK_W = DATA_W + HEAD_W;
  localparam int BUF_W   = BLOCK_W + PMA_W - 1;
  localparam logic [CNT_W-1:0] C_BLOCK = CNT_W'(BLOCK_W);
  localparam logic [CNT_W-1:0] C_PMA   = CNT_W'(PMA_W);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  generate
    if (PMA_W < 8 || PMA_W > BLOCK_W) begin : g_bad_pma_w
      $error("gearbox_rx_flex: PMA_W must be in 8..BLOCK_W");
    end
  endgenerate

  logic [BUF_W-1:0]  buf_q, buf_d, comb;
  logic [CNT_W-1:0]  cnt_q, cnt_d, tot;
  logic              valid_q, valid_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    comb    = buf_q | ({{(BUF_W-PMA_W){1'b0}}, data_i} << cnt_q);
    tot     = cnt_q + C_PMA;
    // Slip is resolved before the completion test, so it can postpone a block.
    if (slip_v_i) begin
      comb = comb >> 1;
      tot  = tot - C_ONE;
    end
    buf_d   = comb;
    cnt_d   = tot;
    valid_d = 1'b0;
    head_d  = head_q;
    data_d  = data_q;
    if (!lock_v_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (tot >= C_BLOCK) begin
      valid_d          = 1'b1;
      {data_d, head_d} = comb[BLOCK_W-1:0];
      buf_d            = comb >> BLOCK_W;
      cnt_d            = tot - C_BLOCK;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_gearbox_rx_flex.sv
// ============================================================================
// tb_gearbox_rx_flex : scoreboard bench for PMA_W=64 and PMA_W=32 instances
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gearbox_rx_flex;

  typedef struct {
    int          cyc;
    logic [1:0]  h;
    logic [63:0] d;
  } exp_t;

  typedef struct {
    string        nm;
    logic [127:0] act;
    logic [127:0] exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        nreset;
  logic        lock64, slip64, lock32, slip32;
  logic [63:0] d64;
  logic [31:0] d32;
  logic        v64, v32;
  logic [1:0]  h64, h32;
  logic [63:0] o64, o32;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   nv64 = 0;
  int   nv32 = 0;
  bit   prev32 = 1'b0;
  bit   done = 1'b0;

  exp_t eq64[$];
  exp_t eq32[$];
  chk_t chkq[$];
  bit   mb64[$];
  bit   mb32[$];
  bit   src[$];

  gearbox_rx_flex #(.PMA_W(64)) u_dut64 (
    .clk(clk), .nreset(nreset), .lock_v_i(lock64), .data_i(d64),
    .slip_v_i(slip64), .valid_o(v64), .head_o(h64), .data_o(o64)
  );

  gearbox_rx_flex #(.PMA_W(32)) u_dut32 (
    .clk(clk), .nreset(nreset), .lock_v_i(lock32), .data_i(d32),
    .slip_v_i(slip32), .valid_o(v32), .head_o(h32), .data_o(o32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the wire is a FIFO of bits; every 66 bits form one block.
  task automatic model(input int pw, input bit lk, input bit sl, input logic [63:0] w);
    bit   q[$];
    exp_t e;
    if (pw == 64) q = mb64; else q = mb32;
    if (!lk) begin
      q.delete();
    end else begin
      for (int i = 0; i < pw; i++) q.push_back(w[i]);
      if (sl) void'(q.pop_front());
      if (q.size() >= 66) begin
        e.cyc = cyc + 1;
        for (int k = 0; k < 2; k++)  e.h[k] = q.pop_front();
        for (int k = 0; k < 64; k++) e.d[k] = q.pop_front();
        if (pw == 64) eq64.push_back(e); else eq32.push_back(e);
      end
    end
    if (pw == 64) mb64 = q; else mb32 = q;
  endtask

  task automatic step(input int pw, input bit lk, input bit sl, input logic [63:0] w);
    if (pw == 64) begin
      lock64 = lk; slip64 = sl; d64 = w;
      lock32 = 1'b0; slip32 = 1'b0; d32 = '0;
      model(64, lk, sl, w);
      model(32, 1'b0, 1'b0, '0);
    end else begin
      lock32 = lk; slip32 = sl; d32 = w[31:0];
      lock64 = 1'b0; slip64 = 1'b0; d64 = '0;
      model(32, lk, sl, {32'h0, w[31:0]});
      model(64, 1'b0, 1'b0, '0);
    end
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    chk_t c;
    c.nm = nm; c.act = act; c.exp = exp;
    chkq.push_back(c);
  endtask

  task automatic do_reset(input bit lk);
    nreset = 1'b0;
    lock64 = lk; slip64 = 1'b0; d64 = {$urandom, $urandom};
    lock32 = lk; slip32 = 1'b0; d32 = $urandom;
    mb64.delete(); mb32.delete();
    @(negedge clk);
    nreset = 1'b1;
    lock64 = 1'b0; lock32 = 1'b0;
    check("reset64", {61'h0, v64, h64, o64}, '0);
    check("reset32", {61'h0, v32, h32, o32}, '0);
  endtask

  task automatic add_block(input logic [1:0] h, input logic [63:0] d);
    src.push_back(h[0]);
    src.push_back(h[1]);
    for (int i = 0; i < 64; i++) src.push_back(d[i]);
  endtask

  function automatic logic [63:0] take(input int pw);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < pw; i++) if (src.size() != 0) w[i] = src.pop_front();
    return w;
  endfunction

  task automatic stream(input int pw, input int nwords, input int slip_at);
    for (int k = 1; k <= nwords; k++) step(pw, 1'b1, k == slip_at, take(pw));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(64, 1'b0, 1'b0, '0);
  endtask

  // Monitor: compares every presented block against the scoreboard.
  always @(negedge clk) begin
    chk_t c;
    exp_t e;
    while (chkq.size() != 0) begin
      c = chkq.pop_front();
      n_checks++;
      if (c.act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %h, required %h", c.nm, c.act, c.exp);
      end
    end
    if (v64 === 1'b1) begin
      n_checks++; nv64++;
      if (eq64.size() == 0 || eq64[0].cyc != cyc) begin
        n_err++;
        $display("FAIL blk64 cyc=%0d: got valid h=%b d=%h, required no block", cyc, h64, o64);
      end else begin
        e = eq64.pop_front();
        if (h64 !== e.h || o64 !== e.d) begin
          n_err++;
          $display("FAIL blk64 cyc=%0d: got h=%b d=%h, required h=%b d=%h", cyc, h64, o64, e.h, e.d);
        end
      end
    end else if (eq64.size() != 0 && eq64[0].cyc == cyc) begin
      e = eq64.pop_front();
      n_checks++; n_err++;
      $display("FAIL blk64 cyc=%0d: got valid=%b, required block h=%b d=%h", cyc, v64, e.h, e.d);
    end
    if (v32 === 1'b1) begin
      n_checks++; nv32++;
      if (eq32.size() == 0 || eq32[0].cyc != cyc) begin
        n_err++;
        $display("FAIL blk32 cyc=%0d: got valid h=%b d=%h, required no block", cyc, h32, o32);
      end else begin
        e = eq32.pop_front();
        if (h32 !== e.h || o32 !== e.d) begin
          n_err++;
          $display("FAIL blk32 cyc=%0d: got h=%b d=%h, required h=%b d=%h", cyc, h32, o32, e.h, e.d);
        end
      end
      if (prev32) begin
        n_checks++; n_err++;
        $display("FAIL b2b32 cyc=%0d: got two consecutive valid, required gap", cyc);
      end
    end else if (eq32.size() != 0 && eq32[0].cyc == cyc) begin
      e = eq32.pop_front();
      n_checks++; n_err++;
      $display("FAIL blk32 cyc=%0d: got valid=%b, required block h=%b d=%h", cyc, v32, e.h, e.d);
    end
    prev32 = (v32 === 1'b1);
    if (done) begin
      n_checks++;
      if (eq64.size() != 0) begin
        n_err++;
        $display("FAIL drain64: got %0d blocks outstanding, required 0", eq64.size());
      end
      n_checks++;
      if (eq32.size() != 0) begin
        n_err++;
        $display("FAIL drain32: got %0d blocks outstanding, required 0", eq32.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    nreset = 1'b0;
    lock64 = 1'b0; slip64 = 1'b0; d64 = '0;
    lock32 = 1'b0; slip32 = 1'b0; d32 = '0;
    @(negedge clk);

    // Aligned 64b stream: 33 words -> 32 blocks.
    do_reset(1'b0);
    s = nv64;
    src.delete();
    for (int b = 0; b < 32; b++) add_block(2'b01, 64'hAAAA_AAAA_AAAA_AAAA);
    stream(64, 33, 0);
    idle(2);
    check("pulses64", 128'(nv64 - s), 128'd32);

    // Same stream through the 32b instance: 66 words -> 32 blocks.
    do_reset(1'b0);
    s = nv32;
    src.delete();
    for (int b = 0; b < 32; b++) add_block(2'b01, 64'hAAAA_AAAA_AAAA_AAAA);
    stream(32, 66, 0);
    idle(2);
    check("pulses32", 128'(nv32 - s), 128'd32);

    // Leading junk bit removed by a slip on word 1, then without the slip.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(1'b0);
      src.delete();
      src.push_back(1'b1);
      for (int b = 0; b < 20; b++) add_block(2'b01, {$urandom, $urandom});
      stream(64, 21, pass == 0 ? 1 : 0);
      idle(2);
    end

    // Slip on the word where cnt=2 and tot would reach exactly 66.
    do_reset(1'b0);
    src.delete();
    for (int b = 0; b < 40; b++) add_block(2'b01, {$urandom, $urandom});
    stream(64, 40, 33);
    idle(2);

    // Lock loss mid-stream, then a fresh aligned stream.
    do_reset(1'b0);
    src.delete();
    for (int b = 0; b < 10; b++) add_block(2'b01, {$urandom, $urandom});
    stream(64, 7, 0);
    idle(3);
    src.delete();
    for (int b = 0; b < 10; b++) add_block(2'b10, {$urandom, $urandom});
    stream(64, 11, 0);
    idle(2);

    // Single-cycle reset mid-block, then restart.
    src.delete();
    for (int b = 0; b < 10; b++) add_block(2'b01, {$urandom, $urandom});
    stream(64, 3, 0);
    do_reset(1'b1);
    src.delete();
    for (int b = 0; b < 6; b++) add_block(2'b01, {$urandom, $urandom});
    stream(64, 7, 0);
    idle(2);

    // Randomized lock, slip and data on both widths.
    for (int pw = 32; pw <= 64; pw += 32) begin
      do_reset(1'b0);
      for (int k = 0; k < 400; k++)
        step(pw, $urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0, {$urandom, $urandom});
      idle(2);
    end

    idle(2);
    done = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/gearbox_rx_flex.md
Name: gearbox_rx_flex

Overview:
Parametrised successor to the fixed 64->66 RX gearbox. It accepts a PMA word of any width PMA_W, where PMA_W <= BLOCK_W. It accumulates the received bits LSB-first and emits aligned 66b blocks as {data, head}, with a one-bit slip used by the block-lock FSM. It sits between the PMA deserialiser and the descrambler/block-lock logic, and supports 16/32/40/64-bit SerDes widths from one RTL.

Parameters:
PMA_W, 64, width of incoming PMA word; legal range 8..BLOCK_W, elaboration error otherwise.
HEAD_W, 2, sync header width.
DATA_W, 64, block payload width; BLOCK_W = DATA_W + HEAD_W.
CNT_W, $clog2(BLOCK_W+PMA_W), width of internal bit counter.

Ports:
clk  in  1  clock.
nreset  in  1  synchronous active-low reset.
lock_v_i  in  1  PMA word valid / CDR locked; when low, the stream is discontinuous.
data_i  in  PMA_W  PMA word; bit 0 is the oldest on the wire.
slip_v_i  in  1  drop one bit from the stream; sampled only when lock_v_i=1.
valid_o  out  1  head_o/data_o carry a new aligned block this cycle.
head_o  out  HEAD_W  sync header, bits [HEAD_W-1:0] of the block.
data_o  out  DATA_W  payload, bits [BLOCK_W-1:HEAD_W] of the block.

Behaviour:
- State:
  - buf_q: BLOCK_W+PMA_W-1 bits, LSB oldest.
  - cnt_q: 0..BLOCK_W-1, number of valid bits held in buf_q.
  - Output registers for valid_o, head_o and data_o.
- Reset (nreset=0 at posedge): buf_q=0, cnt_q=0, valid_o=0, head_o=0, data_o=0. Reset mid-stream discards all buffered bits; no partial block is ever emitted.
- Cycle with lock_v_i=1:
  - comb = buf_q | (data_i << cnt_q); tot = cnt_q + PMA_W.
  - If slip_v_i=1: comb = comb >> 1; tot = tot - 1. The oldest bit is discarded.
  - If tot >= BLOCK_W:
    - Next cycle valid_o=1, {data_o,head_o} = comb[BLOCK_W-1:0].
    - buf_q <= comb >> BLOCK_W; cnt_q <= tot - BLOCK_W.
  - Else: valid_o <= 0; buf_q <= comb; cnt_q <= tot.
  - At most one block is produced per cycle (guaranteed by PMA_W <= BLOCK_W).
- Cycle with lock_v_i=0:
  - Flush: buf_q <= 0, cnt_q <= 0, valid_o <= 0.
  - slip_v_i is ignored.
  - Realignment restarts from the next locked word.
- Latency: a block is presented exactly one cycle after the clock edge that sampled the input word completing it.
- head_o/data_o hold their last value while valid_o=0. Consumers qualify on valid_o.
- Cadence without slip: valid_o is high for exactly PMA_W/gcd(PMA_W,66)·(PMA_W... stated per width:
  - PMA_W=64: 32 blocks per 33 input words; the single low-valid slot repeats every 33 cycles.
  - PMA_W=32: 16 blocks per 33 words.
- A slip cycle may delay a block by one input word. It never duplicates a bit or reorders bits.
- Back-to-back slips are legal; each removes exactly one bit.
- Slip coinciding with block completion: the slip is applied first, then the completion test on tot-1.
- Bits beyond cnt_q in buf_q are always 0. Bench checks this through the output only: no X/garbage in blocks after reset or flush.

Test Plan:
- PMA_W=64, reset then 33 locked words forming 32 blocks {64'hAAAA_AAAA_AAAA_AAAA, 2'b01} -> valid_o pattern 0,1×32 starting at cycle 2. Every block equals head_o=2'b01, data_o=64'hAAAA_AAAA_AAAA_AAAA; cnt_q returns to 0 after word 33.
- PMA_W=32, same 66b stream (66 words) -> exactly 32 valid_o pulses. Blocks are bit-exact to the scoreboard, with no back-to-back valid_o.
- PMA_W=64, stream offset by 1 bit (leading junk bit), slip_v_i pulsed once with word 1 -> all subsequent blocks have head_o=2'b01 and correct data. Without the slip, head_o is misaligned: 2'b10/2'b11 pattern.
- Slip on the exact cycle tot=BLOCK_W (cnt_q=2, PMA_W=64) -> no block that cycle (tot-1=65). The block appears one word later, bit-exact.
- lock_v_i dropped for 3 cycles mid-stream, then a new aligned stream -> valid_o=0 during loss and the next cycle. The first post-lock block comes from new data only, with no stale bits.
- nreset asserted mid-block for 1 cycle -> valid_o=0, head_o=0, data_o=0 the next cycle. Restart yields first valid_o on the second locked word (PMA_W=64).
